mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory access stage feeding the register write-back selector.
- Takes load/store ops from the control unit plus the ALU-computed address.
- Runs a single-outstanding-request bus handshake and stalls the core until the access completes.
- Returns a lane-aligned, width-extended load value on memload.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, max cycles waiting for busAck. Used only with ACCESS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- nRst  in  1  asynchronous active-low reset
- cuOP  in  6  control-unit op code: LB=10, LH=11, LW=12, LBU=13, LHU=14, SB=15, SH=16, SW=17; all other codes are non-memory ops
- addr  in  32  effective address (ALU output)
- storeData  in  32  rs2 value for stores
- busRead  out  1  read request
- busWrite  out  1  write request
- busAddr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 0
- busWdata  out  32  lane-replicated store data
- busSel  out  4  byte enables
- busRdata  in  32  read data, valid when busAck=1
- busAck  in  1  completion strobe, one cycle
- memload  out  32  load result to write-back
- freeze  out  1  stall request to the core
- misaligned  out  1  one-cycle pulse on a misaligned access
- busError  out  1  one-cycle pulse on timeout (ACCESS_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock domain; asynchronous active-low reset. While nRst=0:
  - state=IDLE
  - all bus outputs 0
  - memload=0, freeze=0, misaligned=0, busError=0, timeout counter=0
  - Reset mid-access abandons the request immediately; a late busAck after reset is ignored (state IDLE).
- States: IDLE, REQ, DONE.
- IDLE, memory op present, aligned:
  - freeze=1 combinationally in the same cycle (cycle 0).
  - Latch op, address, lane info, store data; next state REQ.
- IDLE, non-memory op: freeze=0; no bus activity.
- Alignment rules:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - On a misaligned op in IDLE: misaligned=1 for that cycle, freeze=0, no bus request, memload=0, state stays IDLE.
- REQ:
  - busRead (loads) or busWrite (stores) is held at 1 with busAddr, busSel and busWdata stable every cycle until busAck; freeze=1.
  - On busAck: capture the load result into memload; next state DONE.
  - busAck while IDLE or DONE is ignored.
- DONE:
  - Bus outputs 0, freeze=0, memload holds the result.
  - The core advances on this edge; next state IDLE unconditionally.
  - Minimum access latency: 2 cycles of freeze (cycle 0 IDLE, cycle 1 REQ with immediate ack), DONE in cycle 2.
- busSel:
  - Byte ops: one-hot on addr[1:0].
  - Half ops: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - Word ops: 1111.
- busWdata:
  - SB: storeData[7:0] replicated x4.
  - SH: storeData[15:0] replicated x2.
  - SW: storeData.
- Load data:
  - Select the byte or half from the lane given by the latched addr[1:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- memload after a store completes: 0.
- memload in IDLE holds its last value (not cleared).

Optional Feature:
- Macro ACCESS_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to REQ and increments each REQ cycle without busAck.
  - When the counter reaches TIMEOUT_CYCLES: drop the request, busError=1 for one cycle, memload=0, next state DONE.
  - If busAck arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins and busError=0.
- Undefined: REQ waits indefinitely; busError tied 0; no counter logic.

Test Plan:
- LW at addr 0x100, busAck after 3 REQ cycles, busRdata=0xDEADBEEF:
  - busRead=1, busSel=1111, busAddr=0x100 held 3 cycles.
  - freeze high 4 cycles.
  - memload=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80FF_FF12 → busSel=1000, memload=0xFFFFFF80. Repeat as LBU → memload=0x00000080.
- SH at 0x202 with storeData=0x1234ABCD, immediate ack → busWrite=1, busSel=1100, busWdata=0xABCDABCD, busAddr=0x200, freeze high 2 cycles.
- LW at 0x101 → misaligned=1 for one cycle, freeze=0, busRead=0. Next-cycle ADD op → no bus activity.
- nRst asserted in cycle 2 of a pending LH → all outputs 0 immediately. busAck pulsed after reset release → ignored, state stays IDLE.
- ACCESS_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack → busError pulses after 4 REQ cycles, memload=0, freeze drops. Ack exactly at count 4 → busError=0, data captured.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: single-outstanding bus handshake, core stall, lane-aligned loads.
// Optional ACCESS_TIMEOUT_EN macro adds a REQ timeout counter with a busError pulse.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [5:0]        cuOP,
    input  logic [31:0]       addr,
    input  logic [31:0]       storeData,
    output logic              busRead,
    output logic              busWrite,
    output logic [ADDR_W-1:0] busAddr,
    output logic [31:0]       busWdata,
    output logic [3:0]        busSel,
    input  logic [31:0]       busRdata,
    input  logic              busAck,
    output logic [31:0]       memload,
    output logic              freeze,
    output logic              misaligned,
    output logic              busError
);

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LW  = 6'd12;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  op_q;
    logic [31:0] addr_q, data_q;
    logic        is_byte, is_half, is_word, is_mem;
    logic        bad_align, start;
    logic        q_load, q_byte, q_half;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic        timeout;

    always_comb begin
        is_byte   = (cuOP == OP_LB) || (cuOP == OP_LBU) || (cuOP == OP_SB);
        is_half   = (cuOP == OP_LH) || (cuOP == OP_LHU) || (cuOP == OP_SH);
        is_word   = (cuOP == OP_LW) || (cuOP == OP_SW);
        is_mem    = is_byte || is_half || is_word;
        bad_align = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        start     = is_mem && !bad_align;
    end

    always_comb begin
        q_load = (op_q >= OP_LB) && (op_q <= OP_LHU);
        q_byte = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
        q_half = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
    end

`ifdef ACCESS_TIMEOUT_EN
    logic [7:0] cnt;
    logic       err_q;

    assign timeout  = (state == REQ) && !busAck && (cnt == 8'(TIMEOUT_CYCLES));
    assign busError = err_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt   <= 8'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state != REQ)
                cnt <= 8'd0;
            else if (!busAck)
                cnt <= cnt + 8'd1;
        end
    end
`else
    assign timeout  = 1'b0;
    assign busError = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_nxt  = state;
        freeze     = 1'b0;
        misaligned = 1'b0;
        busRead    = 1'b0;
        busWrite   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    freeze    = 1'b1;
                    state_nxt = REQ;
                end else begin
                    misaligned = is_mem;
                end
            end
            REQ: begin
                freeze   = 1'b1;
                busRead  = q_load;
                busWrite = !q_load;
                if (busAck || timeout)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // core-facing strobes must read 0 while reset is held
        if (!nRst) begin
            freeze     = 1'b0;
            misaligned = 1'b0;
        end
    end

    always_comb begin
        busAddr  = '0;
        busSel   = 4'b0000;
        busWdata = 32'h0;
        if (state == REQ) begin
            busAddr = ADDR_W'({addr_q[31:2], 2'b00});
            unique case (1'b1)
                q_byte: begin
                    busSel   = 4'b0001 << addr_q[1:0];
                    busWdata = {4{data_q[7:0]}};
                end
                q_half: begin
                    busSel   = addr_q[1] ? 4'b1100 : 4'b0011;
                    busWdata = {2{data_q[15:0]}};
                end
                default: begin
                    busSel   = 4'b1111;
                    busWdata = data_q;
                end
            endcase
            if (q_load)
                busWdata = 32'h0;
        end
    end

    always_comb begin
        lane_b = busRdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? busRdata[31:16] : busRdata[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_val = {24'h0, lane_b};
            OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_val = {16'h0, lane_h};
            default: load_val = busRdata;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            op_q    <= 6'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            memload <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                op_q   <= cuOP;
                addr_q <= addr;
                data_q <= storeData;
            end
            if (state == IDLE && is_mem && bad_align)
                memload <= 32'h0;
            if (state == REQ) begin
                if (busAck)
                    memload <= q_load ? load_val : 32'h0;
                else if (timeout)
                    memload <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model drives per-cycle expectations,
// one negedge compare process checks every output, plus literal result pins.
module tb_mem_access_unit;

    localparam int TO = 4;
    localparam logic [5:0] NOP = 6'd0;
    localparam logic [5:0] ADD = 6'd1;
    localparam logic [5:0] LB  = 6'd10;
    localparam logic [5:0] LH  = 6'd11;
    localparam logic [5:0] LW  = 6'd12;
    localparam logic [5:0] LBU = 6'd13;
    localparam logic [5:0] LHU = 6'd14;
    localparam logic [5:0] SB  = 6'd15;
    localparam logic [5:0] SH  = 6'd16;
    localparam logic [5:0] SW  = 6'd17;

    logic        clk = 1'b0;
    logic        nRst;
    logic [5:0]  cuOP;
    logic [31:0] addr, storeData, busRdata;
    logic        busAck;
    logic        busRead, busWrite, freeze, misaligned, busError;
    logic [31:0] busAddr, busWdata, memload;
    logic [3:0]  busSel;

    logic        e_read, e_write, e_freeze, e_mis, e_err;
    logic [31:0] e_addr, e_wdata, e_ml;
    logic [3:0]  e_sel;
    logic [31:0] m_ml;
    logic        chk_en = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          fz_n;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nRst(nRst), .cuOP(cuOP), .addr(addr),
        .storeData(storeData), .busRead(busRead), .busWrite(busWrite),
        .busAddr(busAddr), .busWdata(busWdata), .busSel(busSel),
        .busRdata(busRdata), .busAck(busAck), .memload(memload),
        .freeze(freeze), .misaligned(misaligned), .busError(busError)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busRead", 32'(busRead), 32'(e_read));
            cmp("busWrite", 32'(busWrite), 32'(e_write));
            cmp("busAddr", busAddr, e_addr);
            cmp("busSel", 32'(busSel), 32'(e_sel));
            cmp("busWdata", busWdata, e_wdata);
            cmp("freeze", 32'(freeze), 32'(e_freeze));
            cmp("misaligned", 32'(misaligned), 32'(e_mis));
            cmp("busError", 32'(busError), 32'(e_err));
            cmp("memload", memload, e_ml);
        end
    end

    function automatic logic is_ld(input logic [5:0] op);
        return op <= LHU;
    endfunction

    function automatic logic [3:0] m_sel(input logic [5:0] op, input logic [31:0] a);
        if (op == LB || op == LBU || op == SB) return 4'b0001 << a[1:0];
        if (op == LH || op == LHU || op == SH) return 4'b0011 << (2 * a[1]);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
        if (op == SB) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (op == SH) return {16'h0, d[15:0]} * 32'h0001_0001;
        if (op == SW) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (op)
            LB:      return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            default: return rd;
        endcase
    endfunction

    task automatic quiet_exp();
        e_read = 0; e_write = 0; e_addr = 0; e_sel = 0; e_wdata = 0;
        e_freeze = 0; e_mis = 0; e_err = 0; e_ml = m_ml;
    endtask

    task automatic step();
        @(negedge clk);
        if (freeze === 1'b1) fz_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                             input int n, input logic ack, input logic [31:0] rd);
        fz_n = 0;
        cuOP = op; addr = a; storeData = sd; busAck = 0;
        quiet_exp();
        e_freeze = 1;
        step();
        cuOP = NOP; addr = 32'hFFFF_FFFF; storeData = 32'h0;
        for (int i = 0; i < n; i++) begin
            busAck = ack && (i == n - 1);
            busRdata = busAck ? rd : (32'h5A5A_5A5A ^ i);
            quiet_exp();
            e_read = is_ld(op); e_write = !is_ld(op);
            e_addr = a & 32'hFFFF_FFFC;
            e_sel = m_sel(op, a); e_wdata = m_wdata(op, sd);
            e_freeze = 1;
            step();
        end
        busAck = 0;
        busRdata = 32'h0;
        m_ml = (ack && is_ld(op)) ? m_load(op, a, rd) : 32'h0;
        quiet_exp();
        e_err = !ack;
        step();
        quiet_exp();
        step();
    endtask

    task automatic idle_op(input logic [5:0] op, input logic [31:0] a, input logic mis);
        cuOP = op; addr = a; busAck = 0;
        quiet_exp();
        e_mis = mis;
        step();
        if (mis) m_ml = 32'h0;
    endtask

    initial begin
        nRst = 0; cuOP = LW; addr = 32'h100; storeData = 32'h0;
        busAck = 1; busRdata = 32'hFFFF_FFFF;
        m_ml = 0;
        quiet_exp();
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        cuOP = NOP; busAck = 0; nRst = 1;
        step();

        do_access(LW, 32'h100, 32'h0, 3, 1, 32'hDEAD_BEEF);
        cmp("lw_lit_memload", memload, 32'hDEAD_BEEF);
        cmp("lw_lit_freeze_cycles", 32'(fz_n), 32'd4);
        do_access(LB, 32'h103, 32'h0, 1, 1, 32'h80FF_FF12);
        cmp("lb_lit_memload", memload, 32'hFFFF_FF80);
        do_access(LBU, 32'h103, 32'h0, 1, 1, 32'h80FF_FF12);
        cmp("lbu_lit_memload", memload, 32'h0000_0080);
        do_access(LH, 32'h200, 32'h0, 2, 1, 32'h0000_8765);
        cmp("lh_lit_memload", memload, 32'hFFFF_8765);
        do_access(LHU, 32'h202, 32'h0, 1, 1, 32'h8001_1234);
        cmp("lhu_lit_memload", memload, 32'h0000_8001);
        do_access(SB, 32'h101, 32'h0000_00A5, 1, 1, 32'h0);
        do_access(SW, 32'h10C, 32'hCAFE_F00D, 2, 1, 32'h0);
        do_access(SH, 32'h202, 32'h1234_ABCD, 1, 1, 32'h0);
        cmp("sh_lit_memload", memload, 32'h0);
        cmp("sh_lit_freeze_cycles", 32'(fz_n), 32'd2);

        idle_op(LW, 32'h101, 1);
        idle_op(ADD, 32'h0, 0);
        idle_op(SH, 32'h203, 1);
        idle_op(LHU, 32'h201, 1);
        idle_op(ADD, 32'h4, 0);
        cuOP = NOP; busAck = 1; busRdata = 32'hFFFF_FFFF;
        quiet_exp();
        step();
        busAck = 0;

        do_access(LB, 32'h101, 32'h0, 1, 1, 32'h0000_7F00);
        cmp("lb_pos_lit_memload", memload, 32'h0000_007F);

        cuOP = LH; addr = 32'h204; busAck = 0;
        quiet_exp();
        e_freeze = 1;
        step();
        cuOP = LH;
        quiet_exp();
        e_read = 1; e_addr = 32'h204; e_sel = 4'b0011; e_freeze = 1;
        step();
        nRst = 0;
        m_ml = 0;
        quiet_exp();
        step();
        cuOP = NOP; nRst = 1;
        step();
        busAck = 1; busRdata = 32'hFFFF_FFFF;
        step();
        busAck = 0;
        step();
        cmp("rst_lit_memload", memload, 32'h0);

        do_access(LW, 32'h110, 32'h0, 1, 1, 32'h1357_2468);
        cmp("post_rst_lit_memload", memload, 32'h1357_2468);

`ifdef ACCESS_TIMEOUT_EN
        do_access(LW, 32'h300, 32'h0, TO + 1, 0, 32'h0);
        cmp("to_lit_memload", memload, 32'h0);
        do_access(LW, 32'h304, 32'h0, TO + 1, 1, 32'h1357_9BDF);
        cmp("to_ack_lit_memload", memload, 32'h1357_9BDF);
`endif

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
